// File: rtl/pw_pkg.sv
// pw_pkg: shared definitions for the password sequencer.
//   - 3-bit state encoding constants for the lock FSM
//   - constant helper functions used to size counters and indices
package pw_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_UNLOCK  = 3'd2;
  localparam logic [2:0] ST_ALARM   = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  // Ceiling log2, with a floor of 1 so callers always get a usable width.
  function automatic int pw_clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int pw_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pw_timer.sv
// pw_timer: loadable down-counter.
//   clk, rst  : clock and synchronous active-high reset
//   load      : load load_val this cycle (wins over counting)
//   load_val  : value to load
//   value     : current count; stops at zero
//   done      : terminal count reached (value == 0)
module pw_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/pw_seq_lock.sv
// pw_seq_lock: keypad code checker with timed unlock and lockout.
//   clk, rst     : clock and synchronous active-high reset
//   digit_valid  : one digit accepted per high cycle (IDLE/ENTRY only)
//   digit        : entered digit
//   code         : stored code, digit k at code[k*DIGIT_W +: DIGIT_W], digit 0 first
//   clear        : abort the entry in progress
//   unlock       : door open, held UNLOCK_CYCLES cycles
//   alarm        : 1-cycle pulse on a wrong code, held during lockout
//   locked_out   : lockout active
//   tries_left   : attempts remaining before lockout
//   busy         : entry in progress
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for the first digit
// ST_ENTRY   | collecting digits, mismatch accumulated silently
// ST_UNLOCK  | correct code, door open for UNLOCK_CYCLES
// ST_ALARM   | wrong code, single-cycle alarm
// ST_LOCKOUT | MAX_TRIES consecutive failures, LOCKOUT_CYCLES
module pw_seq_lock
  import pw_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int ENTRY_TIMEOUT  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           digit_valid,
  input  logic [DIGIT_W-1:0]             digit,
  input  logic [CODE_LEN*DIGIT_W-1:0]    code,
  input  logic                           clear,
  output logic                           unlock,
  output logic                           alarm,
  output logic                           locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic                           busy
);

  localparam int IDX_W = pw_clog2(CODE_LEN);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = pw_clog2(pw_max(pw_max(UNLOCK_CYCLES, LOCKOUT_CYCLES), ENTRY_TIMEOUT) + 1);
  localparam bit TO_EN = (ENTRY_TIMEOUT > 0);

  // Timer loads are one less than the duration: the state is left in the
  // cycle where the counter reads zero.
  localparam logic [TMR_W-1:0] LD_UNLOCK = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_LOCK   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_ENTRY  = TMR_W'(TO_EN ? ENTRY_TIMEOUT - 1 : 0);
  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_LEN - 1);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   digit_idx_q, digit_idx_d;
  logic               mismatch_q, mismatch_d;
  logic [TRY_W-1:0]   fail_cnt_q, fail_cnt_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_done;

  logic [DIGIT_W-1:0] code_dig [CODE_LEN];
  logic               digit_miss;
  logic               final_miss;
  logic               last_try;

  for (genvar k = 0; k < CODE_LEN; k++) begin : g_code
    assign code_dig[k] = code[k*DIGIT_W +: DIGIT_W];
  end

  // digit_idx is 0 in IDLE, so the same compare serves the first digit.
  assign digit_miss = (digit != code_dig[digit_idx_q]);
  assign final_miss = mismatch_q | digit_miss;
  assign last_try   = ((int'(fail_cnt_q) + 1) >= MAX_TRIES);

  pw_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    mismatch_d  = mismatch_q;
    fail_cnt_d  = fail_cnt_q;
    tmr_load    = 1'b0;
    tmr_val     = LD_ENTRY;

    case (state_q)
      ST_IDLE: begin
        if (digit_valid) begin
          state_d     = ST_ENTRY;
          digit_idx_d = IDX_W'(1);
          mismatch_d  = digit_miss;
          tmr_load    = 1'b1;
        end
      end

      ST_ENTRY: begin
        if (clear) begin
          state_d     = ST_IDLE;
          digit_idx_d = '0;
          mismatch_d  = 1'b0;
        end else if (digit_valid) begin
          if (digit_idx_q == IDX_LAST) begin
            digit_idx_d = '0;
            mismatch_d  = 1'b0;
            if (!final_miss) begin
              state_d    = ST_UNLOCK;
              fail_cnt_d = '0;
              tmr_load   = 1'b1;
              tmr_val    = LD_UNLOCK;
            end else if (last_try) begin
              state_d    = ST_LOCKOUT;
              fail_cnt_d = TRIES_MAX;
              tmr_load   = 1'b1;
              tmr_val    = LD_LOCK;
            end else begin
              state_d    = ST_ALARM;
              fail_cnt_d = fail_cnt_q + TRY_W'(1);
            end
          end else begin
            digit_idx_d = digit_idx_q + IDX_W'(1);
            mismatch_d  = final_miss;
            tmr_load    = 1'b1;
          end
        end else if (TO_EN && tmr_done) begin
          // Idle too long mid-entry: drop the attempt without charging it.
          state_d     = ST_IDLE;
          digit_idx_d = '0;
          mismatch_d  = 1'b0;
        end
      end

      ST_UNLOCK: begin
        if (tmr_done) state_d = ST_IDLE;
      end

      ST_ALARM: begin
        state_d = ST_IDLE;
      end

      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d    = ST_IDLE;
          fail_cnt_d = '0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        digit_idx_d = '0;
        mismatch_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      digit_idx_q <= '0;
      mismatch_q  <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      mismatch_q  <= mismatch_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign unlock     = (state_q == ST_UNLOCK);
  assign alarm      = (state_q == ST_ALARM) || (state_q == ST_LOCKOUT);
  assign locked_out = (state_q == ST_LOCKOUT);
  assign busy       = (state_q == ST_ENTRY);
  assign tries_left = TRIES_MAX - fail_cnt_q;

endmodule

// File: tb/tb_pw_seq_lock.sv
module tb_pw_seq_lock;

  localparam int DW = 4;
  localparam int CL = 4;
  localparam int MT = 3;
  localparam int UC = 8;
  localparam int LC = 16;
  localparam int ET = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          digit_valid;
  logic [DW-1:0] digit;
  logic [CL*DW-1:0] code;
  logic          clear;
  logic          unlock;
  logic          alarm;
  logic          locked_out;
  logic [1:0]    tries_left;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_unlock, cnt_alarm, cnt_lock;

  // Reference model: the attempt in progress is a queue of digits; timed
  // phases are remaining-cycle counts.
  int m_q[$];
  int m_fails, m_unl, m_lock, m_idle;
  bit m_alarm;

  always #5 clk = ~clk;

  pw_seq_lock #(
    .DIGIT_W(DW), .CODE_LEN(CL), .MAX_TRIES(MT),
    .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(ET)
  ) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .code(code), .clear(clear), .unlock(unlock), .alarm(alarm),
    .locked_out(locked_out), .tries_left(tries_left), .busy(busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int code_digit(input int k);
    return int'((code >> (k * DW)) & 16'hF);
  endfunction

  function automatic void model_step(input bit dv, input int d, input bit clr, input bit r);
    bit ok;
    if (r) begin
      m_q.delete();
      m_fails = 0; m_unl = 0; m_lock = 0; m_idle = 0; m_alarm = 0;
      return;
    end
    if (m_unl > 0) begin
      m_unl--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_alarm) begin
      m_alarm = 0;
    end else if (m_q.size() > 0 && clr) begin
      m_q.delete();
      m_idle = 0;
    end else if (dv) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == CL) begin
        ok = 1;
        for (int k = 0; k < CL; k++) if (m_q[k] != code_digit(k)) ok = 0;
        m_q.delete();
        if (ok) begin
          m_unl = UC;
          m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails >= MT) m_lock = LC;
          else m_alarm = 1;
        end
      end
    end else if (m_q.size() > 0 && ET > 0) begin
      m_idle++;
      if (m_idle >= ET) begin
        m_q.delete();
        m_idle = 0;
      end
    end
  endfunction

  task automatic cyc(input bit dv, input int d, input bit clr, input bit r);
    digit_valid = dv;
    digit       = DW'(d);
    clear       = clr;
    rst         = r;
    @(posedge clk);
    model_step(dv, d, clr, r);
    #1;
    chk("unlock",     int'(unlock),     int'(m_unl > 0));
    chk("alarm",      int'(alarm),      int'(m_alarm || m_lock > 0));
    chk("locked_out", int'(locked_out), int'(m_lock > 0));
    chk("busy",       int'(busy),       int'(m_q.size() > 0));
    chk("tries_left", int'(tries_left), MT - m_fails);
    cnt_unlock += int'(unlock);
    cnt_alarm  += int'(alarm);
    cnt_lock   += int'(locked_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    cyc(1, a, 0, 0);
    cyc(1, b, 0, 0);
    cyc(1, c, 0, 0);
    cyc(1, d, 0, 0);
  endtask

  task automatic zero_counts();
    cnt_unlock = 0; cnt_alarm = 0; cnt_lock = 0;
  endtask

  initial begin
    code = 16'h4321;
    digit_valid = 0; digit = '0; clear = 0; rst = 1;
    zero_counts();
    cyc(0, 0, 0, 1);
    chk("rst_tries", int'(tries_left), 3);
    chk("rst_outs", int'({unlock, alarm, locked_out, busy}), 0);

    // 1: correct code
    zero_counts();
    enter(1, 2, 3, 4);
    chk("s1_unlock_now", int'(unlock), 1);
    idle(12);
    chk("s1_unlock_len", cnt_unlock, 8);
    chk("s1_no_alarm", cnt_alarm, 0);

    // 2: wrong second digit, alarm only after the fourth
    zero_counts();
    cyc(1, 1, 0, 0);
    cyc(1, 9, 0, 0);
    chk("s2_busy_mid", int'(busy), 1);
    chk("s2_no_early_alarm", int'(alarm), 0);
    cyc(1, 3, 0, 0);
    cyc(1, 4, 0, 0);
    chk("s2_alarm_now", int'(alarm), 1);
    idle(3);
    chk("s2_alarm_len", cnt_alarm, 1);
    chk("s2_tries", int'(tries_left), 2);
    enter(1, 2, 3, 4);
    idle(9);

    // 3: three wrong codes -> lockout; correct code during lockout ignored
    zero_counts();
    enter(5, 5, 5, 5); idle(1);
    enter(1, 2, 3, 5); idle(1);
    enter(0, 0, 0, 0);
    chk("s3_locked", int'(locked_out), 1);
    enter(1, 2, 3, 4);
    idle(16);
    chk("s3_lock_len", cnt_lock, 16);
    chk("s3_alarm_len", cnt_alarm, 18);
    chk("s3_unlock_ignored", cnt_unlock, 0);
    chk("s3_tries", int'(tries_left), 3);
    enter(1, 2, 3, 4);
    chk("s3_unlock_after", int'(unlock), 1);
    idle(9);

    // 4: clear beats digit_valid
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 3, 1, 0);
    chk("s4_busy", int'(busy), 0);
    chk("s4_tries", int'(tries_left), 3);
    enter(1, 2, 3, 4);
    chk("s4_unlock", int'(unlock), 1);
    idle(9);

    // 5: entry timeout
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    idle(31);
    chk("s5_busy_31", int'(busy), 1);
    idle(1);
    chk("s5_busy_32", int'(busy), 0);
    chk("s5_tries", int'(tries_left), 3);
    enter(3, 4, 1, 2);
    chk("s5_alarm", int'(alarm), 1);
    chk("s5_no_unlock", int'(unlock), 0);
    idle(2);
    enter(1, 2, 3, 4);
    idle(9);

    // 6: reset mid-lockout and mid-unlock
    enter(5, 5, 5, 5); idle(1);
    enter(5, 5, 5, 5); idle(1);
    enter(5, 5, 5, 5);
    idle(4);
    cyc(0, 0, 0, 1);
    chk("s6_lock_rst_outs", int'({unlock, alarm, locked_out, busy}), 0);
    chk("s6_lock_rst_tries", int'(tries_left), 3);
    enter(1, 2, 3, 4);
    idle(2);
    cyc(0, 0, 0, 1);
    chk("s6_unl_rst_outs", int'({unlock, alarm, locked_out, busy}), 0);
    enter(1, 2, 3, 4);
    chk("s6_unlock_after", int'(unlock), 1);
    idle(9);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int sel, d, pos;
      bit dv, clr, r;
      sel = int'($urandom_range(199));
      if (sel == 0) begin
        idle(int'($urandom_range(28, 40)));
        continue;
      end
      r   = ($urandom_range(299) == 0);
      clr = ($urandom_range(24) == 0);
      dv  = ($urandom_range(9) < 6);
      pos = (m_q.size() < CL) ? m_q.size() : 0;
      if ($urandom_range(4) != 0) d = code_digit(pos);
      else d = int'($urandom_range(15));
      cyc(dv, d, clr, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
